// File: rtl/bit_adder.sv
// Single-bit full adder with an optional one-stage output register.
// The combinational sum/carry are always available; the registered copy
// is captured only on qualified cycles and carries its own valid flag.
module bit_adder #(
    parameter int REG_OUT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic carry_in,
    input  logic in_valid,
    output logic result,
    output logic carry_out,
    output logic result_q,
    output logic carry_out_q,
    output logic out_valid
);

    // Full-adder equations; X/Z on inputs propagate through unmasked.
    always_comb begin
        result    = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic result_r;
            logic carry_out_r;
            logic out_valid_r;

            // Pipeline register: data loads only when qualified and holds otherwise,
            // while valid tracks in_valid of the previous edge; reset wins over capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    result_r    <= 1'b0;
                    carry_out_r <= 1'b0;
                    out_valid_r <= 1'b0;
                end else if (in_valid) begin
                    result_r    <= result;
                    carry_out_r <= carry_out;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end

            assign result_q    = result_r;
            assign carry_out_q = carry_out_r;
            assign out_valid   = out_valid_r;
        end else begin : g_noreg
            // Without the register stage the registered outputs are constant zero.
            assign result_q    = 1'b0;
            assign carry_out_q = 1'b0;
            assign out_valid   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bit_adder.sv
// Self-checking bench for bit_adder: directed scenarios plus randomized
// traffic, compared against an arithmetic reference model. A second
// instance built with REG_OUT=0 is exercised in parallel.
module tb_bit_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic carry_in = 1'b0;
    logic in_valid = 1'b0;

    logic result, carry_out, result_q, carry_out_q, out_valid;
    logic result_n, carry_out_n, result_q_n, carry_out_q_n, out_valid_n;

    int assert_count = 0;
    int fail_count = 0;

    // Reference state of the registered stage; meaningful only after a reset edge.
    logic exp_result_q, exp_carry_q, exp_valid;
    bit model_known = 1'b0;

    bit_adder #(.REG_OUT(1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
        .result(result), .carry_out(carry_out), .result_q(result_q),
        .carry_out_q(carry_out_q), .out_valid(out_valid)
    );

    bit_adder #(.REG_OUT(0)) dut_noreg (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
        .result(result_n), .carry_out(carry_out_n), .result_q(result_q_n),
        .carry_out_q(carry_out_q_n), .out_valid(out_valid_n)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive all inputs together with blocking assignments.
    task automatic applyStimulus(input logic ia, input logic ib, input logic ic,
                                 input logic iv, input logic ir);
        a = ia;
        b = ib;
        carry_in = ic;
        in_valid = iv;
        rst = ir;
    endtask

    // Combinational outputs of both instances against a + b + carry_in.
    task automatic checkComb(input string tag);
        int sum;
        sum = int'(a) + int'(b) + int'(carry_in);
        checkOutput({tag, "_comb"}, {1'b0, carry_out, result}, 3'(sum));
        checkOutput({tag, "_comb_noreg"}, {1'b0, carry_out_n, result_n}, 3'(sum));
    endtask

    // Advance one rising edge, update the model from the inputs present at
    // that edge, then check the registered outputs 1 time unit later.
    task automatic clockAndCheck(input string tag);
        int sum;
        sum = int'(a) + int'(b) + int'(carry_in);
        if (rst === 1'b1) begin
            exp_result_q = 1'b0;
            exp_carry_q  = 1'b0;
            exp_valid    = 1'b0;
            model_known  = 1'b1;
        end else if (in_valid === 1'b1) begin
            exp_result_q = sum[0];
            exp_carry_q  = sum[1];
            exp_valid    = 1'b1;
        end else begin
            exp_valid    = 1'b0;
        end
        @(posedge clk);
        #1;
        if (model_known)
            checkOutput({tag, "_reg"}, {out_valid, carry_out_q, result_q},
                        {exp_valid, exp_carry_q, exp_result_q});
        checkOutput({tag, "_reg_noreg"}, {out_valid_n, carry_out_q_n, result_q_n}, 3'b000);
    endtask

    // Truth-table vector order and required {carry_out, result}.
    logic [2:0] tt_in  [9] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000,
                               3'b110, 3'b011, 3'b101, 3'b111};
    logic [1:0] tt_exp [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b11};

    // Main sequence of directed and randomized scenarios.
    initial begin
        logic [2:0] v;
        @(negedge clk);

        // Truth table, one time unit per vector, fixed expected table.
        for (int i = 0; i < 9; i++) begin
            v = tt_in[i];
            applyStimulus(v[2], v[1], v[0], 1'b0, 1'b0);
            #1;
            checkOutput("truth_table", {1'b0, carry_out, result}, {1'b0, tt_exp[i]});
            checkOutput("truth_table_noreg", {1'b0, carry_out_n, result_n}, {1'b0, tt_exp[i]});
        end

        // Reset for two cycles, then capture 1,1,1.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        clockAndCheck("reset1");
        clockAndCheck("reset2");
        checkOutput("reset_state", {out_valid, carry_out_q, result_q}, 3'b000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        clockAndCheck("capture111");
        checkOutput("capture111_fixed", {out_valid, carry_out_q, result_q}, 3'b111);

        // Hold: capture 0,1,1 then drop in_valid and change inputs.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        clockAndCheck("capture011");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clockAndCheck("hold");
            checkOutput("hold_fixed", {out_valid, carry_out_q, result_q}, 3'b010);
            checkOutput("hold_comb", {1'b0, carry_out, result}, 3'b001);
        end

        // Reset mid-stream discards the pending capture; next edge recaptures.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        clockAndCheck("midreset");
        checkOutput("midreset_fixed", {out_valid, carry_out_q, result_q}, 3'b000);
        rst = 1'b0;
        clockAndCheck("recapture");
        checkOutput("recapture_fixed", {out_valid, carry_out_q, result_q}, 3'b101);

        // Combinational outputs are unaffected by clk and rst activity.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rst = i[1];
            #2;
            checkOutput("independence", {1'b0, carry_out, result}, 3'b010);
        end
        rst = 1'b1;
        @(negedge clk);
        clockAndCheck("resync");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            #1;
            checkComb("random");
            clockAndCheck("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/bit_adder.md
BIT_ADDER -- requirements
Module: bit_adder

Interface
REQ-001 The block SHALL be named bit_adder and have one clock; reset is synchronous and active-high.
REQ-002 Parameter: REG_OUT, default 1, meaning 1 = registered output stage present; 0 = registered outputs tied to 0 and out_valid tied to 0.
REQ-003 Port: clk  input  1  rising-edge clock for the registered stage.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: a  input  1  addend bit A.
REQ-006 Port: b  input  1  addend bit B.
REQ-007 Port: carry_in  input  1  carry into the bit position.
REQ-008 Port: in_valid  input  1  qualifies a, b and carry_in for capture into the registered stage.
REQ-009 Port: result  output  1  combinational sum bit.
REQ-010 Port: carry_out  output  1  combinational carry out.
REQ-011 Port: result_q  output  1  registered sum bit.
REQ-012 Port: carry_out_q  output  1  registered carry out.
REQ-013 Port: out_valid  output  1  registered-output qualifier.

Function
REQ-014 result SHALL equal a XOR b XOR carry_in, combinationally, with zero clock latency.
REQ-015 carry_out SHALL equal (a AND b) OR (a AND carry_in) OR (b AND carry_in), combinationally, with zero clock latency.
REQ-016 result and carry_out SHALL be independent of clk, rst and in_valid, and SHALL settle within the same simulation time step as any input change.
REQ-017 The arithmetic identity {carry_out, result} = a + b + carry_in (2-bit unsigned sum, range 0..3) SHALL hold for all 8 input combinations.
REQ-018 With REG_OUT=1, on each rising clk edge with rst=0 and in_valid=1, result_q and carry_out_q SHALL load the current result and carry_out, and out_valid SHALL be set to 1 (latency: 1 cycle).
REQ-019 On a rising clk edge with rst=0 and in_valid=0, result_q and carry_out_q SHALL hold their values, and out_valid SHALL be cleared to 0.
REQ-020 X or Z on any data input SHALL NOT be masked; outputs may propagate X.
REQ-021 No state machine exists; the registered stage is a single pipeline register.

Reset
REQ-022 On a rising clk edge with rst=1, result_q, carry_out_q and out_valid SHALL be cleared to 0, regardless of in_valid.
REQ-023 Reset SHALL NOT affect the combinational outputs result and carry_out.
REQ-024 rst asserted mid-stream SHALL discard any capture pending on that edge; capture SHALL resume on the first edge with rst=0 and in_valid=1.
REQ-025 Before the first clock edge, the registered outputs are undefined until reset is applied.

Verification
REQ-026 Exhaustive truth table on the combinational outputs, 1 time unit per vector, applied in the order a,b,cin = 000, 100, 010, 001, 000, 110, 011, 101, 111. Required {carry_out, result} = 00, 01, 01, 01, 00, 10, 10, 10, 11.
REQ-027 Registered capture: rst=1 for 2 cycles, giving result_q=0, carry_out_q=0 and out_valid=0; then a=1, b=1, cin=1, in_valid=1, giving result_q=1, carry_out_q=1 and out_valid=1 one edge later.
REQ-028 Hold: after a capture of 0,1,1, set in_valid=0 and change the inputs to 1,0,0. Required: result_q=0, carry_out_q=1 and out_valid=0 for the next 3 edges, while combinational result=1 and carry_out=0.
REQ-029 Reset mid-stream: with in_valid=1 and a=1, b=0, cin=0, assert rst for one edge. Required: all registered outputs are 0 on that edge and recapture on the next edge (result_q=1, out_valid=1).
REQ-030 Independence: toggle clk and rst while a=1, b=1, cin=0 are constant. Required: result=0 and carry_out=1 continuously.
REQ-031 REG_OUT=0 build: the REQ-026 truth table passes, and result_q, carry_out_q and out_valid stay 0.
